// File: rtl/tl_mac_pkg.sv
// Shared types and defaults for the TL16 product accumulator.
// Holds the batch state encoding and the sign-correction helper.
package tl_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int DEF_PROD_W = 32;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_LEN_W  = 8;

    // A ones'-complement negative value is one less than its two's-complement
    // meaning, so adding the sign bit back restores it (negative zero -> 0).
    function automatic logic ones_corr(input logic sign_bit, input logic ones_comp);
        return sign_bit & ones_comp;
    endfunction

endpackage

// File: rtl/tl_mac_accum_sat_add.sv
// Signed ACC_W-bit adder that clamps to the representable range on overflow.
// Purely combinational; o_ovf flags that a clamp happened.
module tl_sat_add #(
    parameter int W = 40
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);

    logic [W-1:0] w_raw;
    logic         w_pos_ovf;
    logic         w_neg_ovf;

    assign w_raw     = i_a + i_b;
    // Overflow only when both operands share a sign the raw result lost.
    assign w_pos_ovf = ~i_a[W-1] & ~i_b[W-1] &  w_raw[W-1];
    assign w_neg_ovf =  i_a[W-1] &  i_b[W-1] & ~w_raw[W-1];
    assign o_ovf     = w_pos_ovf | w_neg_ovf;

    assign o_sum = w_pos_ovf ? {1'b0, {(W-1){1'b1}}} :
                   w_neg_ovf ? {1'b1, {(W-1){1'b0}}} :
                   w_raw;

endmodule

// File: rtl/tl_mac_accum.sv
// Batched saturating accumulator for TL16 log-multiplier products, producing
// an approximate dot product behind a valid/ready handshake.
module tl_mac_accum
    import tl_mac_pkg::*;
#(
    parameter int PROD_W    = DEF_PROD_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter bit ONES_COMP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat,
    output logic              busy
);

    state_t             r_state;
    state_t             w_state;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_sat;

    logic               w_accept;
    logic [LEN_W-1:0]   w_len_m1;
    logic [ACC_W-1:0]   w_term;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf;

    // in_ready never looks at in_valid; it only opens up in HOLD when the
    // consumer is taking the result, which lets a new batch start that edge.
    assign in_ready  = (r_state != ST_HOLD) | out_ready;
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state == ST_ACCUM);
    assign out_acc   = r_acc;
    assign out_sat   = r_sat;

    assign w_accept = in_valid & in_ready;
    assign w_len_m1 = (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);
    assign w_term   = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod}
                    + ACC_W'(ones_corr(in_prod[PROD_W-1], ONES_COMP));

    tl_sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_term),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_comb begin
        w_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state = (w_len_m1 == '0) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept && (r_cnt == LEN_W'(1))) begin
                    w_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state = (w_len_m1 == '0) ? ST_HOLD : ST_ACCUM;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state;
            if (w_accept) begin
                if (r_state == ST_ACCUM) begin
                    r_acc <= w_sum;
                    r_sat <= r_sat | w_ovf;
                    r_cnt <= r_cnt - LEN_W'(1);
                end else begin
                    // First product of a batch loads directly, no add.
                    r_acc <= w_term;
                    r_sat <= 1'b0;
                    r_cnt <= w_len_m1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tl_mac_accum.sv
// Directed scoreboard bench for tl_mac_accum: a default 40-bit instance and
// a 33-bit instance share stimulus; a reference model fills result queues.
module tb_tl_mac_accum;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        out_ready;

    logic        in_ready, out_valid, out_sat, busy;
    logic [39:0] out_acc;
    logic        in_ready33, out_valid33, out_sat33, busy33;
    logic [32:0] out_acc33;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_wait   = 0;
    int vcnt        = 0;
    bit vcnt_en     = 1'b0;

    logic [40:0] q40[$];
    logic [33:0] q33[$];

    longint m_acc40, m_acc33;
    bit     m_sat40, m_sat33;
    bit     m_busy;
    int     m_left;

    tl_mac_accum u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    tl_mac_accum #(.ACC_W(33)) u_dut33 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready33),
        .in_prod   (in_prod),
        .out_valid (out_valid33),
        .out_ready (out_ready),
        .out_acc   (out_acc33),
        .out_sat   (out_sat33),
        .busy      (busy33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (vcnt_en && out_valid) vcnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Result handoff happens on the posedge following a negedge where
    // out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("res40_present", 64'(q40.size() != 0), 64'd1);
            if (q40.size() != 0) chk("res40", 64'({out_sat, out_acc}), 64'(q40.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid33 && out_ready) begin
            chk("res33_present", 64'(q33.size() != 0), 64'd1);
            if (q33.size() != 0) chk("res33", 64'({out_sat33, out_acc33}), 64'(q33.pop_front()));
        end
    end

    function automatic longint sadd(input longint a, input longint b, input int w, inout bit s);
        longint hi, lo, r;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        r  = a + b;
        if (r > hi) begin r = hi; s = 1'b1; end
        else if (r < lo) begin r = lo; s = 1'b1; end
        return r;
    endfunction

    task automatic model_accept(input logic [31:0] p, input logic [7:0] len);
        longint t;
        logic [40:0] e40;
        logic [33:0] e33;
        t = longint'($signed(p)) + longint'(p[31]);
        if (!m_busy) begin
            m_acc40 = t; m_acc33 = t;
            m_sat40 = 1'b0; m_sat33 = 1'b0;
            m_left  = (len == 8'd0) ? 0 : int'(len) - 1;
        end else begin
            m_acc40 = sadd(m_acc40, t, 40, m_sat40);
            m_acc33 = sadd(m_acc33, t, 33, m_sat33);
            m_left--;
        end
        if (m_left == 0) begin
            e40 = {m_sat40, m_acc40[39:0]};
            e33 = {m_sat33, m_acc33[32:0]};
            q40.push_back(e40);
            q33.push_back(e33);
            m_busy = 1'b0;
        end else begin
            m_busy = 1'b1;
        end
    endtask

    task automatic put(input logic [31:0] p, input logic [7:0] len);
        int n;
        n = 0;
        cfg_len  = len;
        in_prod  = p;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        chk("accept_in_budget", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_prod  = 32'hDEAD_BEEF;
        model_accept(p, len);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_busy = 1'b0;
    endtask

    initial begin
        int n;
        int c0;
        rst_n = 1'b0; cfg_len = 8'd0; in_valid = 1'b0; in_prod = 32'd0; out_ready = 1'b1;
        m_busy = 1'b0; m_left = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_acc",   64'(out_acc),   64'd0);
        chk("rst_out_sat",   64'(out_sat),   64'd0);

        // 1: three-product batch, ones'-complement negative term
        put(32'd100, 8'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        put(32'd200, 8'd3);
        put(32'hFFFF_FF9B, 8'd3);
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        chk("t1_acc", 64'(out_acc), 64'd200);
        @(posedge clk); #1;

        // 2: zero length means one; negative zero maps to 0
        put(32'd5, 8'd0);
        chk("t2_acc5", 64'(out_acc), 64'd5);
        @(posedge clk); #1;
        put(32'hFFFF_FFFF, 8'd0);
        @(posedge clk); #1;

        // 3: overflow in the 33-bit instance, then sat cleared on next batch
        repeat (3) put(32'h7FFF_FFFF, 8'd3);
        chk("t3_sat33", 64'(out_sat33), 64'd1);
        @(posedge clk); #1;
        put(32'h1, 8'd1);
        @(posedge clk); #1;

        // 4: consumer stall, then handoff and accept in the same cycle
        out_ready = 1'b0;
        put(32'd10, 8'd2);
        put(32'd20, 8'd2);
        cfg_len = 8'd1; in_prod = 32'd1234; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_in_ready",   64'(in_ready),   64'd0);
            chk("t4_stall_in_ready33", 64'(in_ready33), 64'd0);
            chk("t4_stall_valid",      64'(out_valid),  64'd1);
            chk("t4_stall_acc",        64'(out_acc),    64'd30);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        put(32'd1234, 8'd1);
        chk("t4_no_bubble", 64'(last_wait), 64'd0);
        chk("t4_new_acc",   64'(out_acc),   64'd1234);
        @(posedge clk); #1;

        // 5: two length-2 batches streamed back to back
        vcnt = 0; vcnt_en = 1'b1;
        c0 = cyc;
        put(32'd1, 8'd2);
        put(32'd2, 8'd2);
        put(32'd3, 8'd2);
        put(32'd4, 8'd2);
        chk("t5_four_cycles", 64'(cyc - c0), 64'd4);
        repeat (2) @(posedge clk);
        #1 vcnt_en = 1'b0;
        chk("t5_valid_cycles", 64'(vcnt), 64'd2);

        // 6: reset mid-batch discards everything
        put(32'd50, 8'd4);
        put(32'd60, 8'd4);
        chk("t6_busy_before", 64'(busy), 64'd1);
        do_reset();
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_busy",  64'(busy),      64'd0);
        chk("t6_acc",   64'(out_acc),   64'd0);
        @(posedge clk); #1;
        chk("t6_valid_later", 64'(out_valid), 64'd0);
        put(32'd7, 8'd1);
        chk("t6_acc7", 64'(out_acc), 64'd7);

        n = 0;
        while ((q40.size() != 0 || q33.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_q40", 64'(q40.size()), 64'd0);
        chk("drain_q33", 64'(q33.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
